// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction byte loader.
package loader_pkg;

  localparam int unsigned DEFAULT_DEPTH = 64;

  localparam logic [7:0] START_BYTE = 8'hFE;
  localparam logic [7:0] END_BYTE   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-byte assembler; presents the completed word combinationally
// alongside the 4th byte so the caller can register it in the same edge.
module byte_packer (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic        word_valid_c,
  output logic [31:0] word_c
);

  logic [23:0] asm_q;

  always_ff @(posedge clk_i) begin
    if (reset || clear) begin
      byte_idx <= 2'd0;
      asm_q    <= 24'd0;
    end else if (en) begin
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    asm_q[7:0]   <= byte_in;
        2'd1:    asm_q[15:8]  <= byte_in;
        2'd2:    asm_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  // Byte 3 never lands in the register; it is merged on the way out.
  assign word_valid_c = en && (byte_idx == 2'd3);
  assign word_c       = {byte_in, asm_q};

endmodule

// File: rtl/instr_byte_loader.sv
// Frames the START/END-delimited byte stream and writes packed 32-bit words
// into instruction memory, reporting load progress to the core.
module instr_byte_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [7:0]        instr_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              loading_o,
  output logic              load_done_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              overflow_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  load_state_t state, state_next;

  logic        clear_c;
  logic        data_en_c;
  logic        write_c;
  logic        loading_next_c;
  logic        done_next_c;
  logic [1:0]  byte_idx;
  logic        word_valid_c;
  logic [31:0] word_c;

  byte_packer u_packer (
    .clk_i        (clk_i),
    .reset        (reset),
    .clear        (clear_c),
    .en           (data_en_c),
    .byte_in      (instr_i),
    .byte_idx     (byte_idx),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and framing decisions
  always_comb begin
    state_next = state;
    clear_c    = 1'b0;
    data_en_c  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (instr_i == START_BYTE) begin
          state_next = LOAD;
          clear_c    = 1'b1;
        end
      end
      LOAD: begin
        // END only terminates on a word boundary; elsewhere it is data.
        if ((byte_idx == 2'd0) && (instr_i == END_BYTE)) state_next = DONE;
        else                                              data_en_c  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    write_c        = word_valid_c && (word_count_o < CNT_W'(DEPTH));
    loading_next_c = (state_next == LOAD);
    done_next_c    = (state_next == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_data_o  <= 32'd0;
      loading_o    <= 1'b0;
      load_done_o  <= 1'b0;
      word_count_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      imem_we_o   <= write_c;
      loading_o   <= loading_next_c;
      load_done_o <= done_next_c;
      if (write_c) begin
        imem_addr_o <= word_count_o[ADDR_W-1:0];
        imem_data_o <= word_c;
      end
      if (clear_c) begin
        word_count_o <= '0;
        overflow_o   <= 1'b0;
      end else if (write_c) begin
        word_count_o <= word_count_o + CNT_W'(1);
      end else if (word_valid_c) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule
